// File: rtl/conv_window_streamer.sv
// Streams channel-interleaved pixels through per-channel line buffers and emits
// KERNEL_SIZE x KERNEL_SIZE windows for every channel on one flat bus.
module conv_window_streamer #(
   parameter int KERNEL_SIZE = 3,
   parameter int CHANNELS    = 3,
   parameter int DATA_WIDTH  = 16,
   parameter int MAX_WIDTH   = 1024,
   parameter int DIM_WIDTH   = 11
) (
   input  logic                                               axi_clk,
   input  logic                                               axi_reset,
   input  logic                                               cfg_start,
   input  logic [DIM_WIDTH-1:0]                               cfg_width,
   input  logic [DIM_WIDTH-1:0]                               cfg_height,
   input  logic [1:0]                                         cfg_stride,
   output logic                                               busy,
   output logic                                               cfg_err,
   input  logic                                               s_axis_valid,
   input  logic [31:0]                                        s_axis_data,
   input  logic                                               s_axis_last,
   output logic                                               s_axis_ready,
   output logic                                               win_valid,
   input  logic                                               win_ready,
   output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
   output logic [DIM_WIDTH-1:0]                               win_col,
   output logic [DIM_WIDTH-1:0]                               win_row,
   output logic                                               win_last
);
   localparam int K  = KERNEL_SIZE;
   localparam int WB = CHANNELS*K*K*DATA_WIDTH;
   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [DIM_WIDTH-1:0] KD   = DIM_WIDTH'(K);
   localparam logic [DIM_WIDTH-1:0] KM1  = DIM_WIDTH'(K-1);
   localparam logic [DIM_WIDTH-1:0] CHM1 = DIM_WIDTH'(CHANNELS-1);
   localparam logic [DIM_WIDTH-1:0] ONE  = DIM_WIDTH'(1);
   localparam logic [31:0]          MAXW = 32'(MAX_WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                 state_q;
   logic [DIM_WIDTH-1:0]   w_q, h_q, ch_q, col_q, row_q;
   logic [1:0]             sm1_q, xph_q, yph_q;
   logic                   busy_q, err_q, ovalid_q, olast_q;
   logic [WB-1:0]          odata_q;
   logic [DIM_WIDTH-1:0]   ocol_q, orow_q;

   logic [DATA_WIDTH-1:0]  lb_q  [CHANNELS][K-1][MAX_WIDTH];
   logic [DATA_WIDTH-1:0]  win_q [CHANNELS][K][K];
   logic [DATA_WIDTH-1:0]  win_d [CHANNELS][K][K];
   logic [WB-1:0]          win_flat;

   logic [DATA_WIDTH-1:0]  sample;
   logic [AW-1:0]          addr;
   logic                   beat, last_ch, last_col, last_row, final_beat, early;
   logic                   qualify, cfg_bad, is_last_win;
   logic [DIM_WIDTH:0]     step;
   logic                   unused_bits;

   assign sample       = s_axis_data[DATA_WIDTH-1:0];
   assign unused_bits  = ^(s_axis_data >> DATA_WIDTH);
   assign addr         = col_q[AW-1:0];
   assign s_axis_ready = (state_q == RUN) && !(ovalid_q && !win_ready);
   assign beat         = s_axis_valid && s_axis_ready;
   assign last_ch      = (ch_q == CHM1);
   assign last_col     = (col_q == w_q - ONE);
   assign last_row     = (row_q == h_q - ONE);
   assign final_beat   = last_ch && last_col && last_row;
   assign early        = s_axis_last && !final_beat;
   assign qualify      = beat && last_ch && !early && (col_q >= KM1) && (row_q >= KM1)
                         && (xph_q == 2'd0) && (yph_q == 2'd0);
   assign cfg_bad      = (cfg_width < KD) || (cfg_height < KD) || (32'(cfg_width) > MAXW);

   // Final window: no further stride step fits in either direction (x+S >= W, y+S >= H).
   assign step        = {{(DIM_WIDTH-1){1'b0}}, sm1_q} + (DIM_WIDTH+1)'(1);
   assign is_last_win = ({1'b0, col_q} + step >= {1'b0, w_q}) &&
                        ({1'b0, row_q} + step >= {1'b0, h_q});

   assign busy     = busy_q;
   assign cfg_err  = err_q;
   assign win_valid = ovalid_q;
   assign win_data = odata_q;
   assign win_col  = ocol_q;
   assign win_row  = orow_q;
   assign win_last = olast_q;

   always_comb begin
      win_d = win_q;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (beat && (ch_q == DIM_WIDTH'(c))) begin
            for (int unsigned r = 0; r < K; r++)
               for (int unsigned k = 0; k < K-1; k++)
                  win_d[c][r][k] = win_q[c][r][k+1];
            for (int unsigned r = 0; r < K-1; r++)
               win_d[c][r][K-1] = lb_q[c][r][addr];
            win_d[c][K-1][K-1] = sample;
         end
      end
   end

   always_comb begin
      win_flat = '0;
      for (int unsigned c = 0; c < CHANNELS; c++)
         for (int unsigned r = 0; r < K; r++)
            for (int unsigned k = 0; k < K; k++)
               win_flat[((c*K + r)*K + k)*DATA_WIDTH +: DATA_WIDTH] = win_d[c][r][k];
   end

   // Line buffers shift up one line per column on write; read happens above via win_d.
   always_ff @(posedge axi_clk) begin
      win_q <= win_d;
      if (beat) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_q == DIM_WIDTH'(c)) begin
               for (int unsigned r = 0; r < K-2; r++)
                  lb_q[c][r][addr] <= lb_q[c][r+1][addr];
               lb_q[c][K-2][addr] <= sample;
            end
         end
      end
   end

   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         state_q  <= IDLE;
         w_q      <= '0;
         h_q      <= '0;
         ch_q     <= '0;
         col_q    <= '0;
         row_q    <= '0;
         sm1_q    <= '0;
         xph_q    <= '0;
         yph_q    <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         ovalid_q <= 1'b0;
         olast_q  <= 1'b0;
         odata_q  <= '0;
         ocol_q   <= '0;
         orow_q   <= '0;
      end else begin
         if (ovalid_q && win_ready)
            ovalid_q <= 1'b0;
         if (qualify) begin
            ovalid_q <= 1'b1;
            odata_q  <= win_flat;
            ocol_q   <= col_q - KM1;
            orow_q   <= row_q - KM1;
            olast_q  <= is_last_win;
         end
         case (state_q)
            IDLE: begin
               if (cfg_start) begin
                  if (cfg_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     err_q   <= 1'b0;
                     busy_q  <= 1'b1;
                     w_q     <= cfg_width;
                     h_q     <= cfg_height;
                     sm1_q   <= (cfg_stride == 2'd0) ? 2'd0 : cfg_stride - 2'd1;
                     ch_q    <= '0;
                     col_q   <= '0;
                     row_q   <= '0;
                     xph_q   <= '0;
                     yph_q   <= '0;
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (beat) begin
                  if (!last_ch) begin
                     ch_q <= ch_q + ONE;
                  end else begin
                     ch_q <= '0;
                     if (last_col) begin
                        col_q <= '0;
                        xph_q <= '0;
                        row_q <= row_q + ONE;
                        if (row_q >= KM1)
                           yph_q <= (yph_q == 2'd0) ? sm1_q : yph_q - 2'd1;
                     end else begin
                        col_q <= col_q + ONE;
                        if (col_q >= KM1)
                           xph_q <= (xph_q == 2'd0) ? sm1_q : xph_q - 2'd1;
                     end
                  end
                  if (early)
                     err_q <= 1'b1;
                  if (early || final_beat)
                     state_q <= FLUSH;
               end
            end
            FLUSH: begin
               if (!ovalid_q || win_ready)
                  state_q <= DONE;
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_window_streamer.sv
// Directed bench for conv_window_streamer: 8x8 frames, strides 1/2, stalls,
// bad config, early last and mid-frame reset.
module tb_conv_window_streamer;
   localparam int K    = 3;
   localparam int CH   = 3;
   localparam int DW   = 16;
   localparam int DIMW = 11;
   localparam int WB   = CH*K*K*DW;

   logic            clk = 1'b0;
   logic            axi_reset, cfg_start;
   logic [DIMW-1:0] cfg_width, cfg_height;
   logic [1:0]      cfg_stride;
   logic            busy, cfg_err;
   logic            s_axis_valid, s_axis_last, s_axis_ready;
   logic [31:0]     s_axis_data;
   logic            win_valid, win_ready, win_last;
   logic [WB-1:0]   win_data;
   logic [DIMW-1:0] win_col, win_row;

   always #5 clk = ~clk;

   conv_window_streamer #(
      .KERNEL_SIZE(K), .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_WIDTH(64), .DIM_WIDTH(DIMW)
   ) dut (
      .axi_clk(clk), .axi_reset(axi_reset), .cfg_start(cfg_start),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
      .busy(busy), .cfg_err(cfg_err),
      .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
      .s_axis_ready(s_axis_ready),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .win_col(win_col), .win_row(win_row), .win_last(win_last)
   );

   typedef struct packed {
      logic [WB-1:0]   data;
      logic [DIMW-1:0] col;
      logic [DIMW-1:0] row;
      logic            last;
   } win_t;

   win_t q[$];
   win_t held;
   logic prev_stall = 1'b0;
   int   checks = 0, errors = 0, rdy_viol = 0, stall_viol = 0;

   // Records accepted windows and watches payload stability while stalled.
   always @(posedge clk) begin
      if (!axi_reset) begin
         if (prev_stall && (!win_valid || win_data !== held.data || win_col !== held.col ||
                            win_row !== held.row || win_last !== held.last))
            stall_viol++;
         if (win_valid && win_ready)
            q.push_back('{win_data, win_col, win_row, win_last});
      end
      prev_stall = win_valid && !win_ready && !axi_reset;
      held = '{win_data, win_col, win_row, win_last};
   end

   task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] smp(input int mode, input int c, input int x, input int y);
      return DW'(x + 8*y + ((mode == 1) ? 64*c : 0));
   endfunction

   function automatic logic [WB-1:0] ref_win(input int mode, input int col, input int row);
      logic [WB-1:0] f;
      f = '0;
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < K; r++)
            for (int k = 0; k < K; k++)
               f[((c*K + r)*K + k)*DW +: DW] = smp(mode, c, col + k, row + r);
      return f;
   endfunction

   task automatic start(input int w, input int h, input int s);
      cfg_width  = DIMW'(w);
      cfg_height = DIMW'(h);
      cfg_stride = 2'(s);
      cfg_start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   // Feeds an 8x8 frame beat by beat; stops after beat index 'stop' if it is reached.
   task automatic feed(input int mode, input int stop, input bit last_at_stop, input bit rnd);
      int idx;
      idx = 0;
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            for (int c = 0; c < CH; c++) begin
               bit acc;
               int guard;
               acc = 1'b0;
               guard = 0;
               s_axis_valid = 1'b1;
               s_axis_data  = {16'hA5A5 ^ 16'(idx), smp(mode, c, x, y)};
               s_axis_last  = (idx == stop) ? last_at_stop : (idx == 8*8*CH - 1);
               while (!acc && guard < 200) begin
                  win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                  #1;
                  if (s_axis_ready !== !(win_valid && !win_ready))
                     rdy_viol++;
                  acc = s_axis_ready;
                  @(negedge clk);
                  guard++;
               end
               if (!acc) begin
                  chk("feed_timeout", 0, 1);
                  s_axis_valid = 1'b0;
                  s_axis_last  = 1'b0;
                  return;
               end
               if (idx == stop) begin
                  s_axis_valid = 1'b0;
                  s_axis_last  = 1'b0;
                  return;
               end
               idx++;
            end
         end
      end
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
   endtask

   task automatic wait_idle(input bit rnd, input string tag);
      int n;
      n = 0;
      while (busy && n < 100) begin
         win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         n++;
      end
      win_ready = 1'b1;
      chk(tag, busy, 0);
   endtask

   task automatic check_run(input string tag, input int mode, input int s);
      int n;
      n = (8 - K) / s + 1;
      chk({tag, ".count"}, q.size(), n*n);
      for (int i = 0; i < n*n; i++) begin
         if (i < q.size()) begin
            chk($sformatf("%s.col[%0d]", tag, i), q[i].col, (i % n) * s);
            chk($sformatf("%s.row[%0d]", tag, i), q[i].row, (i / n) * s);
            chk($sformatf("%s.last[%0d]", tag, i), q[i].last, (i == n*n - 1));
            chk($sformatf("%s.data[%0d]", tag, i), q[i].data, ref_win(mode, (i % n) * s, (i / n) * s));
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".busy"},    busy, 0);
      chk({tag, ".cfg_err"}, cfg_err, 0);
      chk({tag, ".ready"},   s_axis_ready, 0);
      chk({tag, ".valid"},   win_valid, 0);
      chk({tag, ".data"},    win_data, 0);
      chk({tag, ".col"},     win_col, 0);
      chk({tag, ".row"},     win_row, 0);
      chk({tag, ".last"},    win_last, 0);
   endtask

   initial begin
      axi_reset = 1'b1; cfg_start = 1'b0; cfg_width = '0; cfg_height = '0; cfg_stride = '0;
      s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0; win_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      axi_reset = 1'b0;
      @(negedge clk);

      // Stride 1, identical samples on every channel.
      q.delete();
      start(8, 8, 1);
      chk("A.busy_start", busy, 1);
      feed(0, -1, 1'b0, 1'b0);
      wait_idle(1'b0, "A.idle");
      check_run("A", 0, 1);
      if (q.size() >= 36) begin
         chk("A.first_c0", q[0].data[9*DW-1:0],
             {16'd18, 16'd17, 16'd16, 16'd10, 16'd9, 16'd8, 16'd2, 16'd1, 16'd0});
         chk("A.last_c2_22", q[35].data[26*DW +: DW], 63);
      end
      chk("A.cfg_err", cfg_err, 0);

      // Stride 2, channel-distinct samples.
      q.delete();
      start(8, 8, 2);
      feed(1, -1, 1'b0, 1'b0);
      wait_idle(1'b0, "B.idle");
      check_run("B", 1, 2);

      // Random output backpressure.
      q.delete();
      rdy_viol = 0;
      stall_viol = 0;
      start(8, 8, 1);
      feed(1, -1, 1'b0, 1'b1);
      wait_idle(1'b1, "C.idle");
      check_run("C", 1, 1);
      chk("C.ready_rule", rdy_viol, 0);
      chk("C.stall_stable", stall_viol, 0);

      // Bad configuration.
      start(2, 8, 1);
      chk("BAD.cfg_err", cfg_err, 1);
      chk("BAD.busy", busy, 0);
      chk("BAD.ready", s_axis_ready, 0);
      repeat (2) @(negedge clk);
      chk("BAD.busy_hold", busy, 0);

      // Valid restart clears the error; last arrives early on pixel (3,4).
      q.delete();
      start(8, 8, 1);
      chk("E.cfg_err_clr", cfg_err, 0);
      chk("E.busy", busy, 1);
      feed(0, ((4*8) + 3)*CH, 1'b1, 1'b0);
      for (int n = 0; n < 3 && busy; n++) @(negedge clk);
      chk("E.busy_fall", busy, 0);
      chk("E.cfg_err", cfg_err, 1);
      repeat (5) @(negedge clk);
      chk("E.count", q.size(), 13);
      if (q.size() >= 13) begin
         chk("E.last_col", q[12].col, 0);
         chk("E.last_row", q[12].row, 2);
      end

      // Reset in the middle of a frame, then a clean frame.
      q.delete();
      start(8, 8, 1);
      feed(1, 100, 1'b0, 1'b0);
      axi_reset = 1'b1;
      s_axis_valid = 1'b1;
      @(posedge clk);
      #1;
      check_zero("R.mid");
      @(negedge clk);
      axi_reset = 1'b0;
      s_axis_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("R.no_win", win_valid, 0);
      chk("R.idle_ready", s_axis_ready, 0);
      q.delete();
      start(8, 8, 1);
      feed(1, -1, 1'b0, 1'b0);
      wait_idle(1'b0, "R.idle");
      check_run("R", 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv_window_streamer.md
Name: conv_window_streamer

Overview:
- Parametrised successor to the convolution front end's fixed 3x3 data windowing.
- Accepts a channel-interleaved AXI4-Stream pixel feed and buffers KERNEL_SIZE-1 lines per channel in internal line memories.
- Emits complete KERNEL_SIZE x KERNEL_SIZE windows for all channels at once, with runtime frame size and stride.
- The output feeds the per-channel multiplier/accumulator arrays, flat bus for flat bus.

Parameters:
- KERNEL_SIZE, 3: window edge length K, at least 2.
- CHANNELS, 3: interleaved channels per pixel, at least 1.
- DATA_WIDTH, 16: bits kept per sample; taken from s_axis_data[DATA_WIDTH-1:0], upper bits ignored.
- MAX_WIDTH, 1024: maximum line length in pixels; sets line-buffer depth.
- DIM_WIDTH, 11: width of the dimension and coordinate fields.

Ports:
- axi_clk  in  1  sole clock.
- axi_reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse: latch cfg_* and begin a frame; honoured only in IDLE.
- cfg_width  in  DIM_WIDTH  frame width in pixels.
- cfg_height  in  DIM_WIDTH  frame height in lines.
- cfg_stride  in  2  window step in x and y, 1..3; 0 is treated as 1.
- busy  out  1  high from accepted cfg_start until DONE exits.
- cfg_err  out  1  sticky; set by a bad config or an early last; cleared by the next accepted cfg_start.
- s_axis_valid  in  1  input sample valid.
- s_axis_data  in  32  one channel sample per beat, channel 0 first.
- s_axis_last  in  1  marks the final beat of the frame.
- s_axis_ready  out  1  input accept.
- win_valid  out  1  window valid.
- win_ready  in  1  window accept.
- win_data  out  CHANNELS*K*K*DATA_WIDTH  flat window bus.
- win_col  out  DIM_WIDTH  left pixel column of the window.
- win_row  out  DIM_WIDTH  top line of the window.
- win_last  out  1  high on the final window of the frame.

Behaviour:
- Reset: every output is 0 and the state is IDLE. Line-buffer contents are don't-care. Reset mid-frame abandons the frame; no window is emitted until a new cfg_start.
- States are IDLE, RUN, FLUSH, DONE.
- IDLE:
  - s_axis_ready = 0.
  - On cfg_start, if cfg_width < K, cfg_height < K, or cfg_width > MAX_WIDTH: set cfg_err and stay in IDLE.
  - Otherwise latch the config, clear the column/line/channel counters and go to RUN.
- Beat acceptance: a beat is accepted when s_axis_valid && s_axis_ready. The channel counter advances per beat; the column counter advances when channel = CHANNELS-1; the line counter advances at column wrap.
- Storage: each accepted sample is written to the line buffer of its channel at its column. The column shift register of the K most recent lines for that channel shifts in the sample plus the K-1 stored samples above it (read-before-write at the same address).
- Window qualification: a window is produced when the last-channel beat of pixel (x,y) is accepted and all of these hold:
  - x >= K-1 and y >= K-1;
  - (x-K+1) mod stride = 0;
  - (y-K+1) mod stride = 0.
- Window coordinates: win_col = x-K+1, win_row = y-K+1.
- Latency: win_valid rises the cycle after the qualifying beat is accepted. win_data, win_col, win_row and win_last are registered and held stable while win_valid && !win_ready.
- Window layout: element (c, r, k) sits at bit offset ((c*K + r)*K + k)*DATA_WIDTH. r=0 is the top (oldest) line and k=0 is the leftmost column.
- Backpressure:
  - s_axis_ready = (state==RUN) && !(win_valid && !win_ready).
  - No window is ever dropped or duplicated. A window accepted in the same cycle a new one qualifies is replaced without a bubble.
- Window count: ((W-K)/S + 1) * ((H-K)/S + 1), integer division.
- win_last is asserted with the window at win_col = ((W-K)/S)*S and win_row = ((H-K)/S)*S.
- End of frame: after the beat at (W-1, H-1, CHANNELS-1) go to FLUSH.
  - s_axis_last on that beat is expected.
  - s_axis_last on any earlier beat sets cfg_err and goes to FLUSH; no further windows are produced.
  - A missing last on the final beat is ignored.
- FLUSH: s_axis_ready = 0. Wait until the output register is empty or accepted, then go to DONE.
- DONE: lasts one cycle, busy drops, then IDLE.
- Arithmetic: counters are DIM_WIDTH bits. Stride phase uses down-counters reloaded to stride-1, with no dividers.

Test Plan:
- K=3, CH=3, W=H=8, stride 1, sample = col+8*line for all channels, win_ready=1 -> 36 windows. First window channel 0 = {0,1,2,8,9,10,16,17,18}. win_last at col 5, row 5 with channel 2 element (2,2) = 63.
- Same frame, stride 2 -> 9 windows at cols/rows {0,2,4}. win_last at (4,4). No window at odd coordinates.
- Random win_ready (50%) with continuous s_axis_valid -> identical window sequence to the unstalled run. s_axis_ready low exactly while a window is pending unaccepted. Payload stable during stalls.
- cfg_start with width=2 -> cfg_err=1, busy stays 0, s_axis_ready stays 0. A valid cfg_start afterwards clears cfg_err.
- s_axis_last on the beat of pixel (3,4) -> cfg_err=1, no further windows, busy falls within 3 cycles.
- axi_reset asserted mid-frame -> next cycle all outputs 0. A following 8x8 frame yields exactly 36 correct windows.
